// File: rtl/vc_render_pkg.sv
// Shared geometry, cell attribute layout and prefetcher state encoding
// for the virtual console renderer.
package vc_render_pkg;

    localparam int COLOR_NUMBERS_BITS   = 4;
    localparam int HEIGHT_PER_CHARACTER = 20;
    localparam int WIDTH_PER_CHARACTER  = 8;
    localparam int COLUMNS              = 80;
    localparam int ROWS                 = 24;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] ch;
    } cell_attr_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} prefetch_state_t;

endpackage

// File: rtl/glyph_row_expander.sv
// Registered stage turning one glyph row plus fg/bg into eight colour indices.
// Holds its last output while no valid cell is presented.
import vc_render_pkg::*;

module glyph_row_expander (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    input  logic [6:0]                    in_col,
    input  logic [WIDTH_PER_CHARACTER-1:0] font_data,
    input  logic [COLOR_NUMBERS_BITS-1:0] fg,
    input  logic [COLOR_NUMBERS_BITS-1:0] bg,
    input  logic                          swap,
    output logic                          lb_we,
    output logic [6:0]                    lb_addr,
    output logic [31:0]                   lb_data
);

    logic                          lb_we_q, lb_we_d;
    logic [6:0]                    lb_addr_q, lb_addr_d;
    logic [31:0]                   lb_data_q, lb_data_d;
    logic [COLOR_NUMBERS_BITS-1:0] on_col, off_col;

    always_comb begin
        on_col    = swap ? bg : fg;
        off_col   = swap ? fg : bg;
        lb_we_d   = in_vld;
        lb_addr_d = in_vld ? in_col : lb_addr_q;
        lb_data_d = lb_data_q;
        if (in_vld) begin
            // bit 7 of the glyph row is the leftmost pixel, which lands in the low nibble
            for (int i = 0; i < WIDTH_PER_CHARACTER; i++) begin
                lb_data_d[COLOR_NUMBERS_BITS*i +: COLOR_NUMBERS_BITS] =
                    font_data[WIDTH_PER_CHARACTER-1-i] ? on_col : off_col;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_we_q   <= 1'b0;
            lb_addr_q <= '0;
            lb_data_q <= '0;
        end else begin
            lb_we_q   <= lb_we_d;
            lb_addr_q <= lb_addr_d;
            lb_data_q <= lb_data_d;
        end
    end

    assign lb_we   = lb_we_q;
    assign lb_addr = lb_addr_q;
    assign lb_data = lb_data_q;

endmodule

// File: rtl/text_line_prefetcher.sv
// Walks one text row, fetches attributes and glyph rows, and fills the scanline buffer.
// First write 4 cycles after start, done 84 cycles after; start while busy is dropped.
import vc_render_pkg::*;

module text_line_prefetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  row_idx,
    input  logic [4:0]  glyph_row,
    input  logic        cursor_en,
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    output logic        busy,
    output logic        done,
    output logic [10:0] text_addr,
    input  logic [15:0] text_data,
    output logic [12:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        lb_we,
    output logic [6:0]  lb_addr,
    output logic [31:0] lb_data
);

    prefetch_state_t state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [1:0]  drain_q, drain_d;
    logic [4:0]  glyph_q, glyph_d;
    logic        cur_line_q, cur_line_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [10:0] text_addr_q, text_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_vld_q, rd_vld_d;
    logic [6:0]  rd_col_q, rd_col_d;
    logic        fnt_vld_q, fnt_vld_d;
    logic [6:0]  fnt_col_q, fnt_col_d;
    logic [3:0]  fnt_fg_q, fnt_fg_d;
    logic [3:0]  fnt_bg_q, fnt_bg_d;
    logic        fnt_hit_q, fnt_hit_d;
    cell_attr_t  rd_attr;

    assign rd_attr = cell_attr_t'(text_data);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        drain_d     = drain_q;
        glyph_d     = glyph_q;
        cur_line_d  = cur_line_q;
        cur_col_d   = cur_col_q;
        text_addr_d = text_addr_q;
        done_d      = 1'b0;
        rd_vld_d    = (state_q == FETCH);
        rd_col_d    = col_q;
        fnt_vld_d   = rd_vld_q;
        fnt_col_d   = rd_col_q;
        fnt_fg_d    = rd_attr.fg;
        fnt_bg_d    = rd_attr.bg;
        fnt_hit_d   = cur_line_q && (rd_col_q == cur_col_q);
        case (state_q)
            IDLE: if (start) begin
                glyph_d    = glyph_row;
                cur_line_d = cursor_en && (cursor_row == row_idx) &&
                             (glyph_row >= 5'(HEIGHT_PER_CHARACTER-2));
                cur_col_d  = cursor_col;
                col_d      = '0;
                if (row_idx >= 5'(ROWS) || glyph_row >= 5'(HEIGHT_PER_CHARACTER)) begin
                    // nothing to fetch: spend one busy cycle, then pulse done
                    state_d = DRAIN;
                    drain_d = 2'd2;
                end else begin
                    state_d     = FETCH;
                    drain_d     = 2'd0;
                    text_addr_d = 11'(row_idx) * 11'(COLUMNS);
                end
            end
            FETCH: begin
                if (col_q == 7'(COLUMNS-1)) begin
                    col_d   = '0;
                    state_d = DRAIN;
                end else begin
                    col_d       = col_q + 7'd1;
                    text_addr_d = text_addr_q + 11'd1;
                end
            end
            DRAIN: begin
                // three cycles let the last cell clear the RAM, ROM and expander stages
                if (drain_q == 2'd2) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            drain_q     <= '0;
            glyph_q     <= '0;
            cur_line_q  <= 1'b0;
            cur_col_q   <= '0;
            text_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_col_q    <= '0;
            fnt_vld_q   <= 1'b0;
            fnt_col_q   <= '0;
            fnt_fg_q    <= '0;
            fnt_bg_q    <= '0;
            fnt_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            drain_q     <= drain_d;
            glyph_q     <= glyph_d;
            cur_line_q  <= cur_line_d;
            cur_col_q   <= cur_col_d;
            text_addr_q <= text_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_vld_q    <= rd_vld_d;
            rd_col_q    <= rd_col_d;
            fnt_vld_q   <= fnt_vld_d;
            fnt_col_q   <= fnt_col_d;
            fnt_fg_q    <= fnt_fg_d;
            fnt_bg_q    <= fnt_bg_d;
            fnt_hit_q   <= fnt_hit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign text_addr = text_addr_q;
    assign font_addr = rd_vld_q ? {rd_attr.ch, glyph_q} : '0;

    glyph_row_expander u_expander (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (fnt_vld_q),
        .in_col    (fnt_col_q),
        .font_data (font_data),
        .fg        (fnt_fg_q),
        .bg        (fnt_bg_q),
        .swap      (fnt_hit_q),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .lb_data   (lb_data)
    );

endmodule

// File: tb/tb_text_line_prefetcher.sv
// Scoreboard bench: text RAM / font ROM models feed the prefetcher, expected
// line-buffer writes are queued at start and matched as they appear.
module tb_text_line_prefetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  row_idx, glyph_row, cursor_row;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic        busy, done, lb_we;
    logic [10:0] text_addr;
    logic [15:0] text_data = '0;
    logic [12:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [6:0]  lb_addr;
    logic [31:0] lb_data;

    text_line_prefetcher dut (
        .clk(clk), .rst(rst), .start(start), .row_idx(row_idx), .glyph_row(glyph_row),
        .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy), .done(done), .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_k = 0;
    int          txt_mode = 0;
    int          fnt_mode = 0;
    int          exp_done = 0;
    int          busy_last = 0;
    bit          active = 1'b0;
    bit          m_inr = 1'b0;
    logic [10:0] m_base = '0;
    logic [4:0]  m_glyph = '0;
    bit          spot_on = 1'b0;
    logic [31:0] spot_data = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] txt_fn(input logic [10:0] a);
        case (txt_mode)
            0:       txt_fn = 16'h1F41;
            1:       txt_fn = {a[3:0], a[7:4] ^ 4'hA, a[7:0] ^ 8'h5A};
            default: txt_fn = 16'h7241;
        endcase
    endfunction

    function automatic logic [7:0] fnt_fn(input logic [12:0] a);
        case (fnt_mode)
            0:       fnt_fn = 8'h81;
            1:       fnt_fn = 8'hF0;
            default: fnt_fn = a[12:5] ^ {3'b000, a[4:0]};
        endcase
    endfunction

    function automatic logic [31:0] exp_pix(input logic [7:0] f, input logic [3:0] fg, input logic [3:0] bg);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = f[7-i] ? fg : bg;
        return r;
    endfunction

    // synchronous-read text RAM and font ROM
    always @(posedge clk) begin
        text_data <= txt_fn(text_addr);
        font_data <= fnt_fn(font_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        int          n;
        logic [15:0] td;
        exp_t        e;
        n = cyc - acc_k + 1;
        if (active) begin
            check_val("busy", busy, n <= busy_last);
            if (m_inr && n >= 1 && n <= 80)
                check_val("text_addr", text_addr, m_base + n - 1);
            if (m_inr && n >= 2 && n <= 81) begin
                td = txt_fn(11'(m_base + n - 2));
                check_val("font_addr", font_addr, {td[7:0], m_glyph});
            end
            if (lb_we) begin
                if (sb.size() == 0) begin
                    check_val("extra_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("lb_addr", lb_addr, e.addr);
                    check_val("lb_data", lb_data, e.data);
                    check_val("write_cycle", n, e.n);
                    if (spot_on && e.addr == 7'd10) check_val("cell10_literal", lb_data, spot_data);
                end
            end
            if (done) begin
                check_val("done_cycle", n, exp_done);
                check_val("writes_missing", sb.size(), 0);
                sb.delete();
                active = 1'b0;
            end
        end else begin
            check_val("idle_we", lb_we, 0);
            check_val("idle_done", done, 0);
        end
    end

    task automatic fill(input int row, input int glyph, input int cen, input int crow,
                        input int ccol, input int poke_n, input int rst_n);
        logic [15:0] td;
        logic [7:0]  fd;
        logic [3:0]  fg, bg;
        exp_t        e;
        int          n;
        row_idx    = 5'(row);
        glyph_row  = 5'(glyph);
        cursor_en  = cen[0];
        cursor_row = 5'(crow);
        cursor_col = 7'(ccol);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_k   = cyc;
        m_base  = 11'(row * 80);
        m_glyph = 5'(glyph);
        m_inr   = (row < 24) && (glyph < 20);
        if (m_inr) begin
            for (int c = 0; c < 80; c++) begin
                td = txt_fn(11'(m_base + c));
                fd = fnt_fn({td[7:0], m_glyph});
                fg = td[11:8];
                bg = td[15:12];
                if (cen != 0 && crow == row && c == ccol && glyph >= 18) begin
                    fg = td[15:12];
                    bg = td[11:8];
                end
                e.addr = 7'(c);
                e.data = exp_pix(fd, fg, bg);
                e.n    = c + 4;
                sb.push_back(e);
            end
            exp_done  = 84;
            busy_last = 83;
        end else begin
            exp_done  = 2;
            busy_last = 1;
        end
        active = 1'b1;
        for (int k = 0; k < 300 && active; k++) begin
            @(negedge clk);
            #1;
            n = cyc - acc_k + 1;
            if (n == poke_n) begin
                start     = 1'b1;
                row_idx   = 5'd3;
                glyph_row = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (n == rst_n) begin
                rst = 1'b1;
                active = 1'b0;
                sb.delete();
                #1;
                check_val("rst_busy", busy, 0);
                check_val("rst_done", done, 0);
                check_val("rst_we", lb_we, 0);
                check_val("rst_text_addr", text_addr, 0);
                check_val("rst_lb_data", lb_data, 0);
                repeat (2) @(negedge clk);
                #1;
                rst = 1'b0;
            end
        end
        if (active) begin
            check_val("fill_timeout", 0, 1);
            active = 1'b0;
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        row_idx = '0; glyph_row = '0; cursor_en = 1'b0; cursor_row = '0; cursor_col = '0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_we", lb_we, 0);
        check_val("reset_text_addr", text_addr, 0);
        check_val("reset_font_addr", font_addr, 0);
        check_val("reset_lb_addr", lb_addr, 0);
        check_val("reset_lb_data", lb_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // uniform cells, glyph row 10000001
        txt_mode = 0; fnt_mode = 0; spot_on = 1'b1; spot_data = 32'hF111111F;
        fill(0, 0, 0, 0, 0, -1, -1);
        // back-to-back: last row, last glyph row, varied cells
        txt_mode = 1; fnt_mode = 2; spot_on = 1'b0;
        fill(23, 19, 0, 0, 0, -1, -1);
        // cursor cell inverted on glyph rows 18..19 only
        txt_mode = 2; fnt_mode = 1; spot_on = 1'b1; spot_data = 32'h22227777;
        fill(5, 18, 1, 5, 10, -1, -1);
        spot_data = 32'h77772222;
        fill(5, 17, 1, 5, 10, -1, -1);
        fill(5, 19, 1, 6, 10, -1, -1);
        spot_on = 1'b0;
        txt_mode = 1; fnt_mode = 2;
        fill(12, 19, 1, 12, 79, -1, -1);
        // out-of-range requests
        fill(24, 0, 0, 0, 0, -1, -1);
        fill(3, 20, 0, 0, 0, -1, -1);
        // start during a fill is ignored
        fill(2, 5, 0, 0, 0, 40, -1);
        repeat (4) @(negedge clk);
        // reset mid-fill, then a clean fill
        fill(7, 3, 0, 0, 0, -1, 50);
        repeat (5) @(negedge clk);
        fill(7, 3, 0, 0, 0, -1, -1);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
